// File: rtl/logic_reduce_acc.sv
// Streaming N-operand bitwise reducer with valid/ready flow control; every combine function is a NAND network.
// Optional LOGIC_REDUCE_B2B_EN: accept the next group's first beat during the result handshake.
module logic_reduce_acc #(
  parameter  int unsigned BIT_LEN = 8,
  parameter  int unsigned MAX_OPS = 16,
  localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         op,
  input  logic [BIT_LEN-1:0] in_data,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BIT_LEN-1:0] out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  state_t             state_q, state_d;
  logic [BIT_LEN-1:0] acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               ovf_q, ovf_d;
  logic               beat, first_beat, hold;
  logic [BIT_LEN-1:0] result;

  function automatic logic [BIT_LEN-1:0] nand2(input logic [BIT_LEN-1:0] a,
                                               input logic [BIT_LEN-1:0] b);
    return ~(a & b);
  endfunction

  // AND/OR/XOR/PASS expressed purely as two-input NAND stages
  function automatic logic [BIT_LEN-1:0] combine(input logic [1:0]         sel,
                                                 input logic [BIT_LEN-1:0] a,
                                                 input logic [BIT_LEN-1:0] b);
    logic [BIT_LEN-1:0] n_ab;
    logic [BIT_LEN-1:0] r;
    n_ab = nand2(a, b);
    r    = '0;
    case (sel)
      2'b00:   r = nand2(n_ab, n_ab);
      2'b01:   r = nand2(nand2(a, a), nand2(b, b));
      2'b10:   r = nand2(nand2(a, n_ab), nand2(b, n_ab));
      default: r = nand2(nand2(b, b), nand2(b, b));
    endcase
    return r;
  endfunction

  assign hold      = (state_q == HOLD);
  assign out_valid = hold;
`ifdef LOGIC_REDUCE_B2B_EN
  assign in_ready  = !hold || out_ready;
`else
  assign in_ready  = !hold;
`endif
  assign beat       = in_valid && in_ready;
  assign first_beat = beat && (state_q != ACC);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  assign result    = op_q[2] ? nand2(acc_q, acc_q) : acc_q;
  assign out_data  = hold ? result : '0;
  assign out_count = hold ? cnt_q : '0;
  assign out_ovf   = hold && ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (beat) begin
          acc_d = combine(op_q[1:0], acc_q, in_data);
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d = HOLD;
          end else if (cnt_inc == MAX_CNT) begin
            state_d = HOLD;
            ovf_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase
    // A first beat may arrive in IDLE, or in HOLD alongside the handshake when back-to-back is enabled
    if (first_beat) begin
      acc_d   = in_data;
      op_d    = op;
      cnt_d   = CNT_W'(1);
      ovf_d   = 1'b0;
      state_d = in_last ? HOLD : ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
